branch_history_table: RTL and testbench

- Direct-mapped table of 2-bit saturating counters that predicts the branch outcome before the comparator resolves it.
- It is trained afterwards with the resolved br_en from the branch comparator.
- It is the consumer end of the comparator's br_en signal: fetch queries it, and execute/writeback updates it.
- It also counts resolved branches and mispredictions for performance reporting.

---
 rtl/branch_history_table.sv | 99 +++++++++
 tb/tb_branch_history_table.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_history_table.sv
`default_nettype none
// ============================================================================
// Module      : branch_history_table
// Description : Direct-mapped 2-bit saturating-counter branch predictor with
//               resolved-branch and misprediction statistics.
// Revision    : 1.0 - initial release
// ============================================================================

module branch_history_table #(
  parameter int          INDEX_BITS = 6,
  parameter logic [1:0]  CTR_INIT   = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pred_pc,
  output logic        pred_taken,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_br_en,
  input  logic        upd_pred,
  output logic        mispredict,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count,
  input  logic        clr_stats
);

  localparam int c_entries = 1 << INDEX_BITS;

  logic [1:0]            r_table [c_entries];
  logic                  r_mispredict;
  logic [31:0]           r_branch_count;
  logic [31:0]           r_mispredict_count;

  logic [INDEX_BITS-1:0] w_pred_idx;
  logic [INDEX_BITS-1:0] w_upd_idx;
  logic [1:0]            w_ctr_cur;
  logic [1:0]            w_ctr_next;
  logic                  w_mispredict;
  logic                  w_unused;

  assign w_pred_idx   = pred_pc[INDEX_BITS+1:2];
  assign w_upd_idx    = upd_pc[INDEX_BITS+1:2];
  assign w_ctr_cur    = r_table[w_upd_idx];
  assign w_mispredict = upd_valid & (upd_br_en ^ upd_pred);

  // Byte offset and tag bits are deliberately discarded; entries alias.
  assign w_unused = ^{pred_pc[31:INDEX_BITS+2], pred_pc[1:0],
                      upd_pc[31:INDEX_BITS+2], upd_pc[1:0]};

  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (upd_br_en) begin
      if (w_ctr_cur != 2'b11) w_ctr_next = w_ctr_cur + 2'd1;
    end else begin
      if (w_ctr_cur != 2'b00) w_ctr_next = w_ctr_cur - 2'd1;
    end
  end

  // Flop-based storage so the asynchronous reset clears every entry at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < c_entries; i++) begin
        r_table[i] <= CTR_INIT;
      end
    end else if (upd_valid) begin
      r_table[w_upd_idx] <= w_ctr_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mispredict       <= 1'b0;
      r_branch_count     <= 32'd0;
      r_mispredict_count <= 32'd0;
    end else begin
      r_mispredict <= w_mispredict;
      if (clr_stats) begin
        r_branch_count     <= 32'd0;
        r_mispredict_count <= 32'd0;
      end else if (upd_valid) begin
        if (r_branch_count != 32'hFFFF_FFFF) begin
          r_branch_count <= r_branch_count + 32'd1;
        end
        if (w_mispredict && (r_mispredict_count != 32'hFFFF_FFFF)) begin
          r_mispredict_count <= r_mispredict_count + 32'd1;
        end
      end
    end
  end

  // Pure table read with no bypass: a same-cycle update shows up next cycle.
  assign pred_taken       = r_table[w_pred_idx][1];
  assign mispredict       = r_mispredict;
  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule

`default_nettype wire

// File: tb/tb_branch_history_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_history_table
// Description : Scoreboard bench for branch_history_table with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_branch_history_table;

  localparam int c_sel_pred  = 0;
  localparam int c_sel_misp  = 1;
  localparam int c_sel_bcnt  = 2;
  localparam int c_sel_mcnt  = 3;

  logic        clk;
  logic        rst;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_br_en;
  logic        upd_pred;
  logic        mispredict;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;
  logic        clr_stats;

  typedef struct {
    int          sel;
    logic [31:0] value;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_errors;
  event sample_ev;
  bit   stim_done;

  branch_history_table #(
    .INDEX_BITS (6),
    .CTR_INIT   (2'b01)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pred_pc          (pred_pc),
    .pred_taken       (pred_taken),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_br_en        (upd_br_en),
    .upd_pred         (upd_pred),
    .mispredict       (mispredict),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count),
    .clr_stats        (clr_stats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_val(input int sel, input logic [31:0] value, input string name);
    exp_t e;
    e.sel   = sel;
    e.value = value;
    e.name  = name;
    exp_q.push_back(e);
  endtask

  task automatic expect_pred(input logic [31:0] pc, input logic value, input string name);
    pred_pc = pc;
    expect_val(c_sel_pred, {31'd0, value}, name);
  endtask

  task automatic expect_stats(input logic [31:0] bc, input logic [31:0] mc, input string name);
    expect_val(c_sel_bcnt, bc, {name, "_bcnt"});
    expect_val(c_sel_mcnt, mc, {name, "_mcnt"});
  endtask

  // Drives one update across a rising edge; returns 1 time unit after that edge.
  task automatic do_update(input logic [31:0] pc, input logic br_en, input logic pred);
    upd_valid = 1'b1;
    upd_pc    = pc;
    upd_br_en = br_en;
    upd_pred  = pred;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: whenever outputs are presented (falling edge or an explicit
  // between-edge sample), pop every pending expectation and compare.
  initial begin
    n_checks = 0;
    n_errors = 0;
    forever begin
      @(negedge clk or sample_ev);
      while (exp_q.size() > 0) begin
        exp_t        e;
        logic [31:0] act;
        e = exp_q.pop_front();
        case (e.sel)
          c_sel_pred: act = {31'd0, pred_taken};
          c_sel_misp: act = {31'd0, mispredict};
          c_sel_bcnt: act = branch_count;
          default:    act = mispredict_count;
        endcase
        n_checks++;
        if (act !== e.value) begin
          n_errors++;
          $display("FAIL %s: actual=0x%08h expected=0x%08h at %0t", e.name, act, e.value, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b0;
    pred_pc   = 32'd0;
    upd_valid = 1'b0;
    upd_pc    = 32'd0;
    upd_br_en = 1'b0;
    upd_pred  = 1'b0;
    clr_stats = 1'b0;
    stim_done = 1'b0;

    // Reset pulse placed entirely between clock edges.
    #2 rst = 1'b1;
    #1;
    expect_pred(32'h0000_0060, 1'b0, "rst_pred");
    expect_val(c_sel_misp, 32'd0, "rst_misp");
    expect_stats(32'd0, 32'd0, "rst");
    -> sample_ev;
    #1 rst = 1'b0;
    idle_cycle();

    // Train index 16 up to strongly taken, then saturate.
    expect_pred(32'h0000_0040, 1'b0, "train_init");
    idle_cycle();
    do_update(32'h0000_0040, 1'b1, 1'b0);
    expect_pred(32'h0000_0040, 1'b1, "train_t1");
    expect_val(c_sel_misp, 32'd1, "train_t1_misp");
    do_update(32'h0000_0040, 1'b1, 1'b1);
    expect_pred(32'h0000_0040, 1'b1, "train_t2");
    expect_val(c_sel_misp, 32'd0, "train_t2_misp");
    do_update(32'h0000_0040, 1'b1, 1'b1);
    expect_pred(32'h0000_0040, 1'b1, "train_t3_sat");

    // Hysteresis down: 11 -> 10 -> 01, then four more hold at 00.
    do_update(32'h0000_0040, 1'b0, 1'b1);
    expect_pred(32'h0000_0040, 1'b1, "down_n1");
    expect_val(c_sel_misp, 32'd1, "down_n1_misp");
    do_update(32'h0000_0040, 1'b0, 1'b1);
    expect_pred(32'h0000_0040, 1'b0, "down_n2");
    for (int i = 0; i < 4; i++) begin
      do_update(32'h0000_0040, 1'b0, 1'b0);
    end
    expect_pred(32'h0000_0040, 1'b0, "down_floor");
    expect_val(c_sel_misp, 32'd0, "down_floor_misp");
    // From a saturated 00, one taken gives 01 (still NT), a second gives 10.
    do_update(32'h0000_0040, 1'b1, 1'b1);
    expect_pred(32'h0000_0040, 1'b0, "floor_up1");
    do_update(32'h0000_0040, 1'b1, 1'b1);
    expect_pred(32'h0000_0040, 1'b1, "floor_up2");

    // Aliasing: 0x140 shares index 16; 0x44 is index 17, untouched.
    do_update(32'h0000_0040, 1'b1, 1'b1);
    do_update(32'h0000_0040, 1'b1, 1'b1);
    expect_pred(32'h0000_0140, 1'b1, "alias_0x140");
    idle_cycle();
    expect_pred(32'h0000_0044, 1'b0, "neighbor_0x44");
    expect_stats(32'd13, 32'd3, "stats_after_train");
    idle_cycle();

    // Standalone clear.
    clr_stats = 1'b1;
    idle_cycle();
    clr_stats = 1'b0;
    expect_stats(32'd0, 32'd0, "clr_alone");

    // Misprediction pattern on index 32.
    do_update(32'h0000_0080, 1'b1, 1'b0);
    expect_val(c_sel_misp, 32'd1, "mp_u1");
    do_update(32'h0000_0080, 1'b1, 1'b1);
    expect_val(c_sel_misp, 32'd0, "mp_u2");
    do_update(32'h0000_0080, 1'b0, 1'b0);
    expect_val(c_sel_misp, 32'd0, "mp_u3");
    do_update(32'h0000_0080, 1'b0, 1'b1);
    expect_val(c_sel_misp, 32'd1, "mp_u4");
    idle_cycle();
    expect_val(c_sel_misp, 32'd0, "mp_no_hold");
    do_update(32'h0000_0080, 1'b1, 1'b1);
    expect_val(c_sel_misp, 32'd0, "mp_u5");
    expect_stats(32'd5, 32'd2, "mp");
    expect_pred(32'h0000_0080, 1'b1, "mp_ctr10");
    idle_cycle();

    // Clear concurrent with a mispredicted update: counts zero, table moves 10 -> 01.
    clr_stats = 1'b1;
    do_update(32'h0000_0080, 1'b0, 1'b1);
    clr_stats = 1'b0;
    expect_stats(32'd0, 32'd0, "clr_upd");
    expect_pred(32'h0000_0080, 1'b0, "clr_upd_table");
    expect_val(c_sel_misp, 32'd1, "clr_upd_misp");
    idle_cycle();

    // Same-cycle read and update of index 48 (at 01): no bypass.
    pred_pc = 32'h0000_00C0;
    expect_val(c_sel_pred, 32'd0, "same_cycle_pre");
    do_update(32'h0000_00C0, 1'b1, 1'b0);
    expect_val(c_sel_pred, 32'd1, "same_cycle_post");
    expect_val(c_sel_misp, 32'd1, "pre_rst_misp");
    expect_stats(32'd1, 32'd1, "pre_rst");
    -> sample_ev;

    // Asynchronous reset between edges.
    #1 rst = 1'b1;
    #1;
    expect_val(c_sel_pred, 32'd0, "async_rst_pred");
    expect_val(c_sel_misp, 32'd0, "async_rst_misp");
    expect_stats(32'd0, 32'd0, "async_rst");
    -> sample_ev;
    @(negedge clk);
    rst = 1'b0;

    // First edge after release behaves as a normal cycle.
    do_update(32'h0000_00C0, 1'b1, 1'b1);
    expect_pred(32'h0000_00C0, 1'b1, "post_rst_pred");
    expect_stats(32'd1, 32'd0, "post_rst");

    repeat (3) idle_cycle();
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    stim_done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
